// File: rtl/countdown_seq_ctrl_if.sv
// countdown_seq_ctrl_if
//   Pushbutton, switch and display bundle for countdown_seq_ctrl.
//   Signals:
//     btnR  - asynchronous "advance" pushbutton (raw, unsynchronized)
//     sw    - 8-bit countdown start value
//     an    - active-low digit anodes (registered in the controller)
//     seg   - active-low segments {g,f,e,d,c,b,a} (registered in the controller)
//     led   - 16 status LEDs (registered in the controller)
//   Modports:
//     master - the board / stimulus side (drives btnR and sw)
//     slave  - the controller side (drives an, seg and led)
interface countdown_seq_ctrl_if;
  logic        btnR;
  logic [7:0]  sw;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] led;

  modport master (output btnR, output sw, input an, input seg, input led);
  modport slave  (input btnR, input sw, output an, output seg, output led);
endinterface

// File: rtl/countdown_seq_ctrl.sv
// countdown_seq_ctrl
//   Pushbutton-driven countdown sequencer with a 4-digit multiplexed
//   seven-segment display and status LEDs.
//   Every press of btnR advances IDLE -> SETVAL -> DISP -> COUNT. From COUNT
//   a press pauses (back to DISP) and reaching zero ends in DONE. A press in
//   DONE clears the value and returns to IDLE.
//   Parameters:
//     TICK_DIV - clk cycles per countdown decrement (>= 2)
//     SCAN_DIV - clk cycles per display digit advance (>= 2)
//   Ports:
//     clk  - system clock, rising edge
//     btnL - asynchronous active-high reset
//     bus  - countdown_seq_ctrl_if.slave (btnR, sw in; an, seg, led out)
//   Build option:
//     CSC_DEBOUNCE_EN - when defined, the synchronized button must be stable
//                       for 16 cycles before its filtered level changes.
module countdown_seq_ctrl #(
  parameter int TICK_DIV = 100000000,
  parameter int SCAN_DIV = 100000
) (
  input logic                  clk,
  input logic                  btnL,
  countdown_seq_ctrl_if.slave  bus
);

  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETVAL = 3'd1,
    DISP   = 3'd2,
    COUNT  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] digit_seg(input logic [1:0] d, input logic [7:0] v,
                                           input state_t st);
    logic [6:0] s;
    case (d)
      2'd0:    s = hex7(v[3:0]);
      2'd1:    s = hex7(v[7:4]);
      2'd2:    s = 7'h7F;
      default: s = hex7({1'b0, st});
    endcase
    return s;
  endfunction

  function automatic logic [15:0] led_word(input state_t st, input logic [7:0] v);
    logic [4:0] oh;
    oh = 5'b00001 << st;
    if (st == DONE) return 16'hFFFF;
    return {3'b000, oh, v};
  endfunction

  // ---- Stage p0/p1: two-flop synchronizer; p2: previous filtered level ----
  logic btnr_p0, btnr_p1, btnr_p2;
  // rel_p0/rel_p1 mark when btnr_p1 holds a real sample taken after reset.
  logic rel_p0, rel_p1;
  // Armed only once the button has been seen released after reset, so a
  // button held through reset release cannot produce a press.
  logic armed;
  logic lvl;
  logic press;

  always_ff @(posedge clk or posedge btnL) begin
    if (btnL) begin
      btnr_p0 <= 1'b0;
      btnr_p1 <= 1'b0;
      btnr_p2 <= 1'b0;
      rel_p0  <= 1'b0;
      rel_p1  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      btnr_p0 <= bus.btnR;
      btnr_p1 <= btnr_p0;
      btnr_p2 <= lvl;
      rel_p0  <= 1'b1;
      rel_p1  <= rel_p0;
      armed   <= armed | (rel_p1 & ~btnr_p1);
    end
  end

`ifdef CSC_DEBOUNCE_EN
  logic [3:0] db_cnt;
  logic       db_lvl;

  // Filtered level follows the synchronizer only after 16 cycles of disagreement.
  always_ff @(posedge clk or posedge btnL) begin
    if (btnL) begin
      db_cnt <= 4'd0;
      db_lvl <= 1'b0;
    end else if (btnr_p1 == db_lvl) begin
      db_cnt <= 4'd0;
    end else if (db_cnt == 4'd15) begin
      db_lvl <= btnr_p1;
      db_cnt <= 4'd0;
    end else begin
      db_cnt <= db_cnt + 4'd1;
    end
  end

  assign lvl = db_lvl;
`else
  assign lvl = btnr_p1;
`endif

  assign press = armed & lvl & ~btnr_p2;

  // ---- Control state ----
  state_t              state, nxt_state;
  logic [7:0]          value, nxt_value;
  logic [TICK_W-1:0]   tick, nxt_tick;
  logic [SCAN_W-1:0]   scan, nxt_scan;
  logic [1:0]          digit, nxt_digit;
  logic                tick_wrap;

  logic [3:0]          an_q;
  logic [6:0]          seg_q;
  logic [15:0]         led_q;

  assign tick_wrap = (tick == TICK_W'(TICK_DIV - 1));

  always_comb begin
    nxt_state = state;
    nxt_value = value;
    nxt_tick  = tick;
    unique case (state)
      IDLE: begin
        if (press) nxt_state = SETVAL;
      end
      SETVAL: begin
        nxt_value = bus.sw;
        if (press) nxt_state = DISP;
      end
      DISP: begin
        if (press) begin
          nxt_tick  = '0;
          nxt_state = COUNT;
        end
      end
      COUNT: begin
        // Press beats a coincident tick wrap; a zero value never decrements.
        if (press) begin
          nxt_state = DISP;
        end else if (value == 8'd0) begin
          nxt_state = DONE;
        end else if (tick_wrap) begin
          nxt_tick  = '0;
          nxt_value = value - 8'd1;
          if (value == 8'd1) nxt_state = DONE;
        end else begin
          nxt_tick = tick + 1'b1;
        end
      end
      DONE: begin
        if (press) begin
          nxt_value = 8'd0;
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    nxt_scan  = scan + 1'b1;
    nxt_digit = digit;
    if (scan == SCAN_W'(SCAN_DIV - 1)) begin
      nxt_scan  = '0;
      nxt_digit = digit + 2'd1;
    end
  end

  // ---- Register stage: outputs are built from next-state values so an,
  // seg and led line up with the state registers on the same edge ----
  always_ff @(posedge clk or posedge btnL) begin
    if (btnL) begin
      state <= IDLE;
      value <= 8'd0;
      tick  <= '0;
      scan  <= '0;
      digit <= 2'd0;
      an_q  <= 4'b1110;
      seg_q <= 7'h40;
      led_q <= 16'h0100;
    end else begin
      state <= nxt_state;
      value <= nxt_value;
      tick  <= nxt_tick;
      scan  <= nxt_scan;
      digit <= nxt_digit;
      an_q  <= ~(4'b0001 << nxt_digit);
      seg_q <= digit_seg(nxt_digit, nxt_value, nxt_state);
      led_q <= led_word(nxt_state, nxt_value);
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.led = led_q;

endmodule
